sobel_gradient: RTL and testbench
=================================

Name: sobel_gradient

Overview:
- Downstream consumer of the 3x3 window buffer in the Sobel edge-detection datapath.
- Accepts one 3x3 window of 8-bit grayscale pixels per handshake and computes Gx, Gy and the approximate magnitude |Gx|+|Gy|.
- Emits one saturated 8-bit edge pixel per window toward the output writer, through a 3-stage pipeline with valid/ready back-pressure.

Parameters:
- PIX_W, 8, pixel width in and out.
- CNT_W, 16, width of the processed-pixel counter.
- THRESH, 8'd128, binarisation threshold; used only when SOBEL_THRESHOLD_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous active-high reset. The name follows the codebase port name; the polarity is active-high regardless of the n_ prefix.
- start_calc  in  1  window valid. windowBufferIn is stable while this is high.
- calc_ready  out  1  block can accept a window this cycle.
- windowBufferIn  in  9 x PIX_W  unpacked [0:8], row-major; 0 = top-left, 4 = centre, 8 = bottom-right.
- pixel_out  out  PIX_W  edge magnitude result.
- calc_done  out  1  pixel_out valid.
- out_ready  in  1  downstream accepts pixel_out this cycle.
- pix_count  out  CNT_W  number of results accepted downstream.

Behaviour:
- Reset values (n_rst high at a rising edge): all stage valid bits 0, calc_done 0, pixel_out 0, pix_count 0, all data registers 0.
- Input handshake: a window transfers when start_calc && calc_ready.
- Output handshake: a result transfers when calc_done && out_ready.
- Stall: stall = calc_done && !out_ready. calc_ready = !stall.
  - While stalled, every stage register holds.
  - Inputs are ignored while stalled.
- S1 (capture): latch the 9 pixels; v1 <= start_calc.
- S2 (convolve):
  - Gx = (w2 + 2*w5 + w8) - (w0 + 2*w3 + w6).
  - Gy = (w6 + 2*w7 + w8) - (w0 + 2*w1 + w2).
  - Both are signed 11-bit, range -1020..+1020, zero-extended operands, no overflow possible.
  - v2 <= v1.
- S3 (magnitude): mag = |Gx| + |Gy|, unsigned 11-bit, max 2040. pixel_out <= (mag > 255) ? 255 : mag[7:0]. calc_done <= v2.
- Latency: 3 cycles from accepted start_calc to calc_done, with no stall.
- Throughput: one window per cycle.
- Bubbles: propagate as v=0. Data registers of an invalid stage may update freely, but calc_done never asserts for a bubble.
- pix_count increments on each output transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous input accept and output transfer in one cycle is legal; the pipeline advances normally.
- Reset mid-operation: all in-flight windows are discarded and no calc_done follows. calc_ready is 1 in the cycle after reset deasserts.
- pixel_out holds its last value while calc_done is low. Downstream must qualify it with calc_done.

Optional Feature:
- Macro SOBEL_THRESHOLD_EN.
- Defined: S3 outputs pixel_out = (mag >= THRESH) ? 8'd255 : 8'd0, a binary edge map. Latency is unchanged.
- Undefined: saturated magnitude as described above. THRESH is unused.

Decomposition:
- Package sobel_pkg holds:
  - PIX_W default, GRAD_W = 11, MAG_W = 11.
  - typedef pixel_t (logic [7:0]).
  - typedef window_t (pixel_t [0:8]).
  - typedef grad_t (logic signed [10:0]).
  - constant PIX_MAX = 8'd255.
- One sub-module, sobel_kernel: purely combinational window_t -> Gx, Gy. Instantiated in S2 and reusable by a future Prewitt variant.
- Pipeline registers, handshake and counter live in the top module.

Test Plan:
- Window all 0, start_calc for 1 cycle, out_ready=1 -> calc_done exactly 3 cycles later, pixel_out = 0, pix_count = 1.
- Window '{0,1,2,3,4,5,6,7,8} -> Gx = 8, Gy = 24, pixel_out = 32.
- Window w6..w8 = 10, others 0 -> Gx = 0, Gy = 40, pixel_out = 40.
- Vertical edge, w2/w5/w8 = 255, others 0 -> Gx = 1020, pixel_out saturates to 255. With SOBEL_THRESHOLD_EN and THRESH = 128, the previous window gives 0 and this one gives 255.
- Back-pressure: stream 5 windows back-to-back while holding out_ready low from cycle 4 for 3 cycles.
  - calc_ready drops while stalled.
  - No result is lost or duplicated; outputs arrive in order.
  - pix_count ends at 5.
- Reset mid-stream: assert n_rst with 2 windows in flight.
  - Next cycle: calc_done = 0, pix_count = 0, pixel_out = 0.
  - No stale calc_done afterward.
  - A new window issued after reset produces a correct result 3 cycles later.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and widths for the Sobel edge-detection datapath.
package sobel_pkg;
  localparam int PIX_W_DEFAULT = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 11;

  typedef logic [7:0]              pixel_t;
  typedef pixel_t [0:8]            window_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

  localparam pixel_t PIX_MAX = 8'd255;
endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel kernel: window -> signed Gx, Gy.
module sobel_kernel
  import sobel_pkg::*;
(
  input  window_t win_i,
  output grad_t   gx_o,
  output grad_t   gy_o
);

  grad_t e [0:8];

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      e[i] = grad_t'({3'b000, win_i[i]});
    end
    gx_o = (e[2] + e[5] + e[5] + e[8]) - (e[0] + e[3] + e[3] + e[6]);
    gy_o = (e[6] + e[7] + e[7] + e[8]) - (e[0] + e[1] + e[1] + e[2]);
  end

endmodule

// File: rtl/sobel_gradient.sv
// 3-stage Sobel gradient pipeline with valid/ready back-pressure.
// Define SOBEL_THRESHOLD_EN for a binary edge map instead of saturated magnitude.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int               PIX_W  = PIX_W_DEFAULT,
  parameter int               CNT_W  = 16,
  parameter logic [PIX_W-1:0] THRESH = 8'd128
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_calc,
  output logic             calc_ready,
  input  logic [PIX_W-1:0] windowBufferIn [0:8],
  output logic [PIX_W-1:0] pixel_out,
  output logic             calc_done,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pix_count
);

  logic             stall;
  logic             vld_p1_q, vld_p2_q, vld_p3_q;
  logic [PIX_W-1:0] win_p1_q [0:8];
  window_t          win_k;
  grad_t            gx_d, gy_d, gx_p2_q, gy_p2_q;
  logic [MAG_W-1:0] mag;
  logic [PIX_W-1:0] pix_d, pix_p3_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  function automatic logic [MAG_W-1:0] abs_grad(input grad_t g);
    return g[GRAD_W-1] ? MAG_W'(-g) : MAG_W'(g);
  endfunction

  function automatic logic [PIX_W-1:0] sat_pix(input logic [MAG_W-1:0] m);
    return (m > MAG_W'(PIX_MAX)) ? PIX_MAX : m[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] thresh_pix(input logic [MAG_W-1:0] m);
    return (m >= MAG_W'(THRESH)) ? PIX_MAX : '0;
  endfunction

  assign stall      = vld_p3_q && !out_ready;
  assign calc_ready = !stall;
  assign calc_done  = vld_p3_q;
  assign pixel_out  = pix_p3_q;
  assign pix_count  = cnt_q;

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_k[i] = win_p1_q[i];
    end
  end

  sobel_kernel u_kernel (
    .win_i (win_k),
    .gx_o  (gx_d),
    .gy_o  (gy_d)
  );

  always_comb begin
    mag = abs_grad(gx_p2_q) + abs_grad(gy_p2_q);
`ifdef SOBEL_THRESHOLD_EN
    pix_d = thresh_pix(mag);
`else
    pix_d = sat_pix(mag);
`endif
    cnt_d = cnt_q + CNT_W'(vld_p3_q && out_ready);
  end

`ifndef SOBEL_THRESHOLD_EN
  logic unused_thresh;
  assign unused_thresh = ^{THRESH, thresh_pix(mag)};
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      win_p1_q <= '{default: '0};
      gx_p2_q  <= '0;
      gy_p2_q  <= '0;
      pix_p3_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) begin
        // S1: capture window
        vld_p1_q <= start_calc;
        if (start_calc) win_p1_q <= windowBufferIn;
        // S2: convolve
        vld_p2_q <= vld_p1_q;
        gx_p2_q  <= gx_d;
        gy_p2_q  <= gy_d;
        // S3: magnitude; pixel_out only moves on a valid result so it holds across bubbles
        vld_p3_q <= vld_p2_q;
        if (vld_p2_q) pix_p3_q <= pix_d;
      end
    end
  end

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed, table-driven bench for sobel_gradient with back-pressure and reset sequences.
module tb_sobel_gradient;
  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start_calc = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  win [0:8];
  logic        calc_ready, calc_done;
  logic [7:0]  pixel_out;
  logic [15:0] pix_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [71:0] w;
    int          mag;
  } vec_t;

  vec_t tv [12];
  int   exp_q [$];

  always #5 clk = ~clk;

  sobel_gradient dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start_calc     (start_calc),
    .calc_ready     (calc_ready),
    .windowBufferIn (win),
    .pixel_out      (pixel_out),
    .calc_done      (calc_done),
    .out_ready      (out_ready),
    .pix_count      (pix_count)
  );

  function automatic logic [71:0] mkw(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic int exp_pix(input int mag);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= 128) ? 255 : 0;
`else
    return (mag > 255) ? 255 : mag;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_win(input logic [71:0] w);
    for (int i = 0; i < 9; i++) win[i] = w[8*i +: 8];
  endtask

  initial begin
    int exp_cnt;
    int idx;
    int got;
    int saw_stall;
    int stale;

    for (int i = 0; i < 9; i++) win[i] = 8'd0;
    // Hand-computed |Gx|+|Gy| for each window
    tv[0]  = '{mkw(0, 0, 0, 0, 0, 0, 0, 0, 0), 0};
    tv[1]  = '{mkw(0, 1, 2, 3, 4, 5, 6, 7, 8), 32};
    tv[2]  = '{mkw(0, 0, 0, 0, 0, 0, 10, 10, 10), 40};
    tv[3]  = '{mkw(0, 0, 255, 0, 0, 255, 0, 0, 255), 1020};
    tv[4]  = '{mkw(255, 0, 0, 255, 0, 0, 255, 0, 0), 1020};
    tv[5]  = '{mkw(100, 0, 0, 0, 0, 0, 0, 0, 0), 200};
    tv[6]  = '{mkw(0, 0, 0, 0, 255, 0, 0, 0, 0), 0};
    tv[7]  = '{mkw(0, 50, 0, 0, 0, 0, 0, 0, 0), 100};
    tv[8]  = '{mkw(0, 0, 0, 0, 0, 60, 0, 70, 0), 260};
    tv[9]  = '{mkw(0, 63, 0, 64, 0, 0, 0, 0, 0), 254};
    tv[10] = '{mkw(0, 0, 0, 0, 0, 0, 0, 0, 64), 128};
    tv[11] = '{mkw(0, 0, 0, 0, 0, 0, 0, 0, 63), 126};

    repeat (2) @(negedge clk);
    chk("reset_calc_done", calc_done, 0);
    chk("reset_pixel_out", pixel_out, 0);
    chk("reset_pix_count", pix_count, 0);
    n_rst = 1'b0;
    @(negedge clk);
    chk("reset_calc_ready", calc_ready, 1);

    exp_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      set_win(tv[k].w);
      start_calc = 1'b1;
      @(negedge clk);
      start_calc = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_early_done", k), calc_done, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done", k), calc_done, 1);
      chk($sformatf("vec%0d_pixel", k), pixel_out, exp_pix(tv[k].mag));
      exp_cnt++;
      @(negedge clk);
      chk($sformatf("vec%0d_done_clear", k), calc_done, 0);
      chk($sformatf("vec%0d_pixel_hold", k), pixel_out, exp_pix(tv[k].mag));
      chk($sformatf("vec%0d_count", k), pix_count, exp_cnt);
    end

    // Back-pressure: 5 back-to-back windows, out_ready low for cycles 4..6
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    idx = 0;
    got = 0;
    saw_stall = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 7);
      if (idx < 5) begin
        start_calc = 1'b1;
        set_win(tv[idx+1].w);
      end else begin
        start_calc = 1'b0;
      end
      #1;
      if (calc_done && !out_ready) begin
        saw_stall++;
        chk("bp_ready_low", calc_ready, 0);
      end
      if (start_calc && calc_ready) begin
        exp_q.push_back(exp_pix(tv[idx+1].mag));
        idx++;
      end
      if (calc_done && out_ready) begin
        chk("bp_in_order", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("bp_pixel", pixel_out, exp_q.pop_front());
        got++;
      end
    end
    start_calc = 1'b0;
    out_ready = 1'b1;
    chk("bp_results", got, 5);
    chk("bp_stall_seen", int'(saw_stall > 0), 1);
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (calc_done) stale++;
    end
    chk("bp_no_duplicate", stale, 0);
    chk("bp_count", pix_count, 5);

    // Reset with two windows in flight
    @(negedge clk);
    set_win(tv[1].w);
    start_calc = 1'b1;
    @(negedge clk);
    set_win(tv[3].w);
    @(negedge clk);
    start_calc = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_done", calc_done, 0);
    chk("rst_mid_count", pix_count, 0);
    chk("rst_mid_pixel", pixel_out, 0);
    n_rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", calc_ready, 1);
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (calc_done) stale++;
    end
    chk("rst_mid_no_stale", stale, 0);

    @(negedge clk);
    set_win(tv[2].w);
    start_calc = 1'b1;
    @(negedge clk);
    start_calc = 1'b0;
    @(negedge clk);
    chk("post_rst_early", calc_done, 0);
    @(negedge clk);
    chk("post_rst_done", calc_done, 1);
    chk("post_rst_pixel", pixel_out, exp_pix(tv[2].mag));
    @(negedge clk);
    chk("post_rst_count", pix_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
